gen_teamplayer: RTL and testbench

- Four-player multitap sequencer. It shares one controller port between four pads.
- It sits between the host port pins (TH/TR driven by the port data/control registers) and four pad button vectors. It returns a nibble stream plus the TL acknowledge to the port's input bits.
- It snapshots all pads at the start of each transaction. It then serves the header, the pad types and the per-pad data nibbles, one nibble per host TR handshake.

---
 rtl/gen_tp_pkg.sv | 46 ++++
 rtl/gen_tp_nibble.sv | 66 ++++++
 rtl/gen_teamplayer.sv | 115 +++++++++++
 tb/tb_gen_teamplayer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/gen_tp_pkg.sv
// Shared types and constants for the four-pad multitap sequencer.
package gen_tp_pkg;

  typedef enum logic [1:0] {
    PT_NONE = 2'b00,
    PT_3BTN = 2'b01,
    PT_6BTN = 2'b10
  } pad_type_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READY,
    S_ACK_WAIT
  } tp_state_e;

  localparam logic [3:0] HDR0 = 4'h3;
  localparam logic [3:0] HDR1 = 4'hF;
  localparam logic [3:0] HDR2 = 4'h0;
  localparam logic [3:0] HDR3 = 4'h0;

  localparam logic [3:0] TYPE_3BTN = 4'h0;
  localparam logic [3:0] TYPE_6BTN = 4'h1;
  localparam logic [3:0] TYPE_NONE = 4'hF;

  localparam logic [3:0] NIB_IDLE = 4'h3;
  localparam logic [3:0] NIB_PAD  = 4'hF;
  localparam logic [4:0] STEP_MAX = 5'd31;

  // The reserved code 11 behaves exactly like an empty port.
  function automatic pad_type_e decode_type(input logic [1:0] raw);
    case (raw)
      2'b01:   return PT_3BTN;
      2'b10:   return PT_6BTN;
      default: return PT_NONE;
    endcase
  endfunction

  function automatic logic [1:0] pad_len(input pad_type_e t);
    case (t)
      PT_3BTN: return 2'd2;
      PT_6BTN: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/gen_tp_nibble.sv
// Combinational nibble selector: header, pad types, then packed per-pad data
// placed at offsets given by a running sum of snapshot pad lengths.
module gen_tp_nibble
  import gen_tp_pkg::*;
(
  input  logic [4:0]  step_i,
  input  logic [7:0]  ptype_i,
  input  logic [47:0] pad_i,
  output logic [3:0]  nib_o
);

  logic [4:0]      didx;
  logic [3:0][3:0] off;
  logic [3:0][3:0] type_nib;
  logic [3:0][3:0] data_nib;
  logic [3:0]      hit;

  assign didx   = step_i - 5'd8;
  assign off[0] = 4'd0;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_pad
      pad_type_e   pt;
      logic [1:0]  len;
      logic [11:0] p;
      logic [4:0]  rel;

      assign pt  = decode_type(ptype_i[2*gi +: 2]);
      assign len = pad_len(pt);
      assign p   = pad_i[12*gi +: 12];
      assign rel = didx - {1'b0, off[gi]};

      if (gi < 3) begin : g_next
        assign off[gi+1] = off[gi] + {2'b00, len};
      end

      assign hit[gi] = (didx >= {1'b0, off[gi]}) && (rel < {3'b000, len});
      assign type_nib[gi] = (pt == PT_3BTN) ? TYPE_3BTN :
                            (pt == PT_6BTN) ? TYPE_6BTN : TYPE_NONE;
      // p bit order is {Z,Y,X,MODE,START,C,B,A,RIGHT,LEFT,DOWN,UP}
      assign data_nib[gi] = (rel[1:0] == 2'd0) ? p[3:0] :
                            (rel[1:0] == 2'd1) ? {p[7], p[4], p[6], p[5]} :
                                                 {p[8], p[9], p[10], p[11]};
    end
  endgenerate

  always_comb begin
    nib_o = NIB_PAD;
    if (step_i < 5'd4) begin
      case (step_i[1:0])
        2'd0:    nib_o = HDR0;
        2'd1:    nib_o = HDR1;
        2'd2:    nib_o = HDR2;
        default: nib_o = HDR3;
      endcase
    end else if (step_i < 5'd8) begin
      nib_o = type_nib[step_i[1:0]];
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (hit[i]) nib_o = data_nib[i];
      end
    end
  end

endmodule

// File: rtl/gen_teamplayer.sv
// Four-pad multitap sequencer: TH/TR handshake FSM, ack delay and snapshot.
// Define GEN_TEAMPLAYER_TIMEOUT_EN to enable the idle-handshake timeout.
module gen_teamplayer
  import gen_tp_pkg::*;
#(
  parameter int ACK_DLY = 4,
  parameter int TIMEOUT = 2047
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CE,
  input  logic        TH_IN,
  input  logic        TR_IN,
  input  logic [7:0]  PTYPE,
  input  logic [47:0] PAD,
  output logic [3:0]  DO,
  output logic        TL,
  output logic        ACTIVE
);

  tp_state_e   state_q;
  logic        th_q, tr_q, tl_q;
  logic [4:0]  step_q, step_d;
  logic [3:0]  dly_q;
  logic [7:0]  snap_type_q;
  logic [47:0] snap_pad_q;
  logic [3:0]  nib;
  logic        th_rise, th_fall, tr_edge, timeout_hit;

  assign th_rise = TH_IN & ~th_q;
  assign th_fall = ~TH_IN & th_q;
  assign tr_edge = TR_IN ^ tr_q;
  assign step_d  = (step_q == STEP_MAX) ? STEP_MAX : step_q + 5'd1;

`ifdef GEN_TEAMPLAYER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      to_q <= '0;
    end else if (CE) begin
      if (state_q == S_IDLE || tr_edge || timeout_hit) to_q <= '0;
      else                                             to_q <= to_q + TO_W'(1);
    end
  end

  assign timeout_hit = (state_q != S_IDLE) && !tr_edge && (to_q == TO_W'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      th_q        <= 1'b1;
      tr_q        <= 1'b1;
      tl_q        <= 1'b1;
      step_q      <= 5'd0;
      dly_q       <= 4'd0;
      snap_type_q <= '0;
      snap_pad_q  <= '1;
    end else if (CE) begin
      th_q <= TH_IN;
      tr_q <= TR_IN;
      // TH release aborts from any state and beats a coincident TR edge.
      if (th_rise || timeout_hit) begin
        state_q <= S_IDLE;
        tl_q    <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (th_fall) begin
              snap_type_q <= PTYPE;
              snap_pad_q  <= PAD;
              step_q      <= 5'd0;
              tl_q        <= TR_IN;
              state_q     <= S_READY;
            end
          end
          S_READY: begin
            if (tr_edge) begin
              step_q  <= step_d;
              dly_q   <= 4'(ACK_DLY);
              state_q <= S_ACK_WAIT;
            end
          end
          S_ACK_WAIT: begin
            if (dly_q == 4'd0) begin
              tl_q    <= TR_IN;
              state_q <= S_READY;
            end else begin
              dly_q <= dly_q - 4'd1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  gen_tp_nibble u_nibble (
    .step_i  (step_q),
    .ptype_i (snap_type_q),
    .pad_i   (snap_pad_q),
    .nib_o   (nib)
  );

  assign DO     = (state_q == S_IDLE) ? NIB_IDLE : nib;
  assign TL     = tl_q;
  assign ACTIVE = (state_q != S_IDLE);

endmodule

// File: tb/tb_gen_teamplayer.sv
// Directed bench for the multitap sequencer: table-driven transactions plus
// hand-written reset, snapshot, abort, clock-enable and timeout sequences.
module tb_gen_teamplayer;

  localparam int ACK = 4;

  logic        CLK = 1'b0;
  logic        RESET, CE, TH_IN, TR_IN;
  logic [7:0]  PTYPE;
  logic [47:0] PAD;
  logic [3:0]  DO;
  logic        TL, ACTIVE;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [7:0]  ptype;
    logic [47:0] pad;
    logic [3:0]  exp [17];
  } txn_t;

  txn_t tbl [3];

  gen_teamplayer #(.ACK_DLY(ACK), .TIMEOUT(100)) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .CE     (CE),
    .TH_IN  (TH_IN),
    .TR_IN  (TR_IN),
    .PTYPE  (PTYPE),
    .PAD    (PAD),
    .DO     (DO),
    .TL     (TL),
    .ACTIVE (ACTIVE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Toggle TR and verify DO right after the edge is seen and the exact TL latency.
  task automatic toggle_checked(input logic [3:0] exp_do);
    logic old_tl;
    old_tl = TL;
    TR_IN = ~TR_IN;
    @(negedge CLK);
    check("do_after_tr", DO, exp_do);
    check("tl_hold_early", {3'b0, TL}, {3'b0, old_tl});
    repeat (ACK) @(negedge CLK);
    check("tl_hold_late", {3'b0, TL}, {3'b0, old_tl});
    @(negedge CLK);
    check("tl_ack", {3'b0, TL}, {3'b0, TR_IN});
  endtask

  task automatic toggle_quiet();
    TR_IN = ~TR_IN;
    repeat (ACK + 2) @(negedge CLK);
  endtask

  task automatic run_txn(input int t);
    PTYPE = tbl[t].ptype;
    PAD   = tbl[t].pad;
    TR_IN = 1'b1;
    @(negedge CLK);
    TH_IN = 1'b0;
    @(negedge CLK);
    check("txn_active", {3'b0, ACTIVE}, 4'h1);
    check("txn_step0", DO, tbl[t].exp[0]);
    check("txn_tl_start", {3'b0, TL}, 4'h1);
    for (int s = 1; s < 17; s++) toggle_checked(tbl[t].exp[s]);
    TH_IN = 1'b1;
    @(negedge CLK);
    check("txn_end_active", {3'b0, ACTIVE}, 4'h0);
    check("txn_end_do", DO, 4'h3);
    check("txn_end_tl", {3'b0, TL}, 4'h1);
    $display("txn %0d ptype=%h done, %0d/%0d so far", t, tbl[t].ptype, n_pass, n_checks);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Spec example: A=3btn UP pressed, B=6btn, C none, D=3btn.
    tbl[0].ptype = 8'h49;
    tbl[0].pad   = {12'hFFF, 12'hFFF, 12'hFFF, 12'hFFE};
    tbl[0].exp   = '{4'h3, 4'hF, 4'h0, 4'h0, 4'h0, 4'h1, 4'hF, 4'h0,
                     4'hE, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
    // No pads (11 codes): absent pads' buttons must never appear.
    tbl[1].ptype = 8'hFF;
    tbl[1].pad   = 48'h0;
    tbl[1].exp   = '{4'h3, 4'hF, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF,
                     4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
    // A none, B 6btn (UP,B,MODE pressed), C code 11, D 3btn (RIGHT,C pressed).
    tbl[2].ptype = 8'h78;
    tbl[2].pad   = {12'hFB7, 12'h000, 12'hEDE, 12'h000};
    tbl[2].exp   = '{4'h3, 4'hF, 4'h0, 4'h0, 4'hF, 4'h1, 4'hF, 4'h0,
                     4'hE, 4'hE, 4'h7, 4'h7, 4'hD, 4'hF, 4'hF, 4'hF, 4'hF};

    RESET = 1'b1; CE = 1'b1; TH_IN = 1'b1; TR_IN = 1'b1;
    PTYPE = 8'h00; PAD = '1;
    repeat (2) @(negedge CLK);
    check("rst_do", DO, 4'h3);
    check("rst_tl", {3'b0, TL}, 4'h1);
    check("rst_active", {3'b0, ACTIVE}, 4'h0);
    RESET = 1'b0;

    // TH held high: TR activity is ignored.
    for (int i = 0; i < 4; i++) begin
      TR_IN = ~TR_IN;
      @(negedge CLK);
      check("idle_do", DO, 4'h3);
      check("idle_tl", {3'b0, TL}, 4'h1);
      check("idle_active", {3'b0, ACTIVE}, 4'h0);
    end

    for (int t = 0; t < 3; t++) run_txn(t);

    // Snapshot: pad A changes after TH falls; only the next transaction sees it.
    PTYPE = 8'h01;
    PAD   = {36'hFFFFFFFFF, 12'hFFE};
    @(negedge CLK);
    TH_IN = 1'b0;
    @(negedge CLK);
    PAD[11:0] = 12'h000;
    repeat (8) toggle_quiet();
    check("snap_old_n0", DO, 4'hE);
    toggle_quiet();
    check("snap_old_n1", DO, 4'hF);
    TH_IN = 1'b1;
    repeat (2) @(negedge CLK);
    TH_IN = 1'b0;
    @(negedge CLK);
    repeat (8) toggle_quiet();
    check("snap_new_n0", DO, 4'h0);
    toggle_quiet();
    check("snap_new_n1", DO, 4'h0);
    TH_IN = 1'b1;
    @(negedge CLK);
    $display("snapshot sequence done, %0d/%0d so far", n_pass, n_checks);

    // Abort: TH rise together with a TR edge while waiting to acknowledge.
    TR_IN = 1'b1;
    @(negedge CLK);
    TH_IN = 1'b0;
    @(negedge CLK);
    toggle_quiet();
    check("abort_tl_low", {3'b0, TL}, 4'h0);
    TR_IN = 1'b1;
    @(negedge CLK);
    TR_IN = 1'b0;
    TH_IN = 1'b1;
    @(negedge CLK);
    check("abort_active", {3'b0, ACTIVE}, 4'h0);
    check("abort_do", DO, 4'h3);
    check("abort_tl", {3'b0, TL}, 4'h1);
    repeat (ACK + 2) @(negedge CLK);
    check("abort_tl_stays", {3'b0, TL}, 4'h1);
    $display("abort sequence done, %0d/%0d so far", n_pass, n_checks);

    // CE low freezes everything, including edge detection.
    PTYPE = 8'h49;
    TH_IN = 1'b0;
    @(negedge CLK);
    toggle_quiet();
    check("ce_pre_do", DO, 4'hF);
    CE = 1'b0;
    TR_IN = 1'b0;
    repeat (10) @(negedge CLK);
    check("ce_hold_do", DO, 4'hF);
    check("ce_hold_tl", {3'b0, TL}, 4'h1);
    check("ce_hold_active", {3'b0, ACTIVE}, 4'h1);
    CE = 1'b1;
    @(negedge CLK);
    check("ce_resume_do", DO, 4'h0);
    repeat (ACK + 2) @(negedge CLK);
    check("ce_resume_tl", {3'b0, TL}, 4'h0);
    $display("clock-enable sequence done, %0d/%0d so far", n_pass, n_checks);

    // Asynchronous reset mid-transaction.
    RESET = 1'b1;
    #2;
    check("mid_rst_do", DO, 4'h3);
    check("mid_rst_tl", {3'b0, TL}, 4'h1);
    check("mid_rst_active", {3'b0, ACTIVE}, 4'h0);
    @(negedge CLK);
    RESET = 1'b0;
    TH_IN = 1'b1;
    @(negedge CLK);
    check("post_rst_active", {3'b0, ACTIVE}, 4'h0);
    $display("reset sequence done, %0d/%0d so far", n_pass, n_checks);

    // Timeout: TH low with no TR activity.
    TH_IN = 1'b0;
    @(negedge CLK);
    check("to_start_active", {3'b0, ACTIVE}, 4'h1);
    repeat (90) @(negedge CLK);
    check("to_before_active", {3'b0, ACTIVE}, 4'h1);
    repeat (20) @(negedge CLK);
`ifdef GEN_TEAMPLAYER_TIMEOUT_EN
    check("to_after_active", {3'b0, ACTIVE}, 4'h0);
    check("to_after_do", DO, 4'h3);
`else
    check("to_after_active", {3'b0, ACTIVE}, 4'h1);
    check("to_after_do", DO, 4'h3);
`endif
    TH_IN = 1'b1;
    @(negedge CLK);
    $display("timeout sequence done, %0d/%0d so far", n_pass, n_checks);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
